tt_um_array_div: RTL
====================

// Module: tt_um_array_div
// PURPOSE
//   Sequential restoring divider, the companion of the 8x8 array multiplier
//   on the same TinyTapeout pin map. It divides a 16-bit dividend by an 8-bit
//   divisor, producing a 16-bit quotient and an 8-bit remainder at one
//   quotient bit per clock. Operands are loaded bytewise over ui_in; results
//   are read back bytewise on uo_out.
// PARAMETERS
//   NW  16  dividend/quotient width (pin map supports only 16)
//   DW   8  divisor/remainder width (pin map supports only 8)
// PORTS
//   clk      in   1  clock, all state on rising edge
//   rst_n    in   1  synchronous active-low reset
//   ena      in   1  design enable; low = every register holds
//   ui_in    in   8  data byte for operand loads
//   uio_in   in   8  [0] ld_lo [1] ld_hi [2] ld_div [3] start [5:4] rd_sel [7:6] unused
//   uo_out   out  8  read mux: rd_sel 0=q[7:0] 1=q[15:8] 2=rem 3=status
//   uio_out  out  8  {busy, done, 6'b0}
//   uio_oe   out  8  constant 8'hC0 (bits 7:6 outputs, rest inputs)
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; dividend, divisor, q, rem, cnt = 0;
//     busy=done=div0=0. uo_out=0 for any rd_sel; uio_out=0.
//   ena=0: no register changes, including operand loads and start.
//   Operand loads (ena=1, state != RUN): ld_lo writes ui_in to dvd[7:0];
//     ld_hi writes dvd[15:8]; ld_div writes dvs. Multiple lds in one cycle all
//     take effect. Loads in RUN are ignored.
//   States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
//   start (ena=1, state IDLE or DONE) at edge T:
//     dvs (pre-edge value) != 0: latch working copies, part=0, cnt=NW-1,
//       state=RUN, done=0, div0=0.
//     dvs == 0: q=16'hFFFF, rem=8'h00, div0=1, state=DONE (done visible after T).
//     Operands loaded in the same cycle as start take effect only for the
//       next operation; start uses pre-edge operand values.
//   RUN, each edge: 9-bit trial t = {part, dvd_msb} - {1'b0, dvs}; if t >= 0
//     then part=t[7:0] and shift 1 into q, else part={part, dvd_msb}[7:0] and
//     shift 0 into q; shift the dividend copy left. Remainder is held in 9 bits
//     internally; the final value always fits in 8.
//     At cnt==0: rem=final part, state=DONE; otherwise cnt decrements.
//     Iterations occur at edges T+1..T+16; busy=1 after T through T+15;
//     done=1 after T+16 (latency 16 cycles).
//   start while RUN is ignored. q/rem hold their previous results until the
//     next start is accepted. During RUN, q/rem show in-progress values; read
//     them only when done=1.
//   DONE holds until the next start or reset. A new start from DONE behaves
//     as from IDLE.
//   Reset mid-RUN: returns to IDLE with all registers cleared on that edge.
//   status byte = {busy, done, div0, 5'b0}.
//   uo_out is a combinational mux of registers and rd_sel (no added latency).
// TESTING
//   1) Load dvd=0x03E8, dvs=0x07, start -> busy for 16 cycles, then done=1;
//      q=0x008E, rem=0x06; status=0x40.
//   2) dvd=0xFFFF, dvs=0xFF -> q=0x0101, rem=0x00; dvd=0x0005, dvs=0x09
//      -> q=0x0000, rem=0x05.
//   3) dvs=0x00, start -> done one cycle later; q=0xFFFF, rem=0x00,
//      status=0x60; busy never asserts.
//   4) Pulse start and ld_div again at cycle 5 of RUN -> both ignored; result
//      matches the original operands; done after exactly 16 cycles.
//   5) rst_n=0 at cycle 8 of RUN -> IDLE next cycle; uo_out=0 for all rd_sel;
//      uio_out=0; uio_oe=0xC0.
//   6) Hold ena=0 for 3 cycles mid-RUN -> done delayed by exactly 3 cycles;
//      result is unchanged. Then randomise 500 operand pairs against a reference
//      q/rem model.

Source files
------------

// File: rtl/tt_um_array_div.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Operands are loaded bytewise over ui_in; results are read bytewise through a mux on uo_out.
module tt_um_array_div #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [NW-1:0] dvd, wdvd, q;
  logic [DW-1:0] dvs, wdvs, part, rem;
  logic [CW-1:0] cnt;
  logic          div0;

  logic          ld_lo, ld_hi, ld_div, start;
  logic [1:0]    rd_sel;
  logic          busy, done;
  logic          unused_ok;

  assign ld_lo     = uio_in[0];
  assign ld_hi     = uio_in[1];
  assign ld_div    = uio_in[2];
  assign start     = uio_in[3];
  assign rd_sel    = uio_in[5:4];
  assign unused_ok = &{1'b0, uio_in[7:6]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // One restoring step. The trial is one bit wider than {part, msb} so its
  // top bit is a clean borrow flag.
  logic [DW:0]   acc;
  logic [DW+1:0] trial;
  logic          fits;
  logic [DW-1:0] part_n;

  always_comb begin
    acc    = {part, wdvd[NW-1]};
    trial  = {1'b0, acc} - {2'b00, wdvs};
    fits   = ~trial[DW+1];
    part_n = fits ? trial[DW-1:0] : acc[DW-1:0];
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    if (ena) begin
      unique case (state)
        IDLE, DONE: if (start) state_n = (dvs != '0) ? RUN : DONE;
        RUN:        if (cnt == '0) state_n = DONE;
        default:    state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values; this is also why a start uses pre-edge operands.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd  <= '0;
      dvs  <= '0;
      wdvd <= '0;
      wdvs <= '0;
      part <= '0;
      q    <= '0;
      rem  <= '0;
      cnt  <= '0;
      div0 <= 1'b0;
    end else if (ena) begin
      if (state != RUN) begin
        if (ld_lo)  dvd[7:0]  <= ui_in;
        if (ld_hi)  dvd[15:8] <= ui_in;
        if (ld_div) dvs       <= ui_in;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (dvs != '0) begin
              wdvd <= dvd;
              wdvs <= dvs;
              part <= '0;
              cnt  <= CW'(NW - 1);
              div0 <= 1'b0;
            end else begin
              q    <= '1;
              rem  <= '0;
              div0 <= 1'b1;
            end
          end
        end
        RUN: begin
          part <= part_n;
          q    <= {q[NW-2:0], fits};
          wdvd <= {wdvd[NW-2:0], 1'b0};
          if (cnt == '0) rem <= part_n;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uo_out = '0;
    unique case (rd_sel)
      2'd0: uo_out = q[7:0];
      2'd1: uo_out = q[15:8];
      2'd2: uo_out = rem;
      2'd3: uo_out = {busy, done, div0, 5'b0};
      default: uo_out = '0;
    endcase
  end

  assign uio_out = {busy, done, 6'b0};
  assign uio_oe  = 8'hC0;

endmodule
